// File: rtl/argmax_stream_pkg.sv
// Shared types and helpers for the streaming argmax.
//   state_e    : FSM state encoding (idle, accumulating, result held).
//   clog2_min1 : ceil(log2(n)), never less than one bit, for counter and lane widths.
package argmax_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_stream_tree.sv
// Combinational P-lane argmax reduction.
//   data_i : P scores, lane j at [j*K +: K]
//   max_o  : largest score
//   lane_o : lane holding it; on ties the lowest lane wins
module argmax_tree
    import argmax_stream_pkg::*;
#(
    parameter int unsigned P      = 1,
    parameter int unsigned K      = 4,
    parameter bit          SIGNED = 1'b0,
    localparam int unsigned LaneW = clog2_min1(P)
) (
    input  logic [P*K-1:0]  data_i,
    output logic [K-1:0]    max_o,
    output logic [LaneW-1:0] lane_o
);

    function automatic logic gt(input logic [K-1:0] a, input logic [K-1:0] b);
        if (SIGNED) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Strict greater-than while scanning upward keeps the earliest lane on ties.
    always_comb begin
        max_o  = data_i[K-1:0];
        lane_o = '0;
        for (int unsigned j = 1; j < P; j++) begin
            if (gt(data_i[j*K +: K], max_o)) begin
                max_o  = data_i[j*K +: K];
                lane_o = LaneW'(j);
            end
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over an N-element score vector delivered P elements per beat.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake; in_data lane j = element beat*P + j
//   out_valid/out_ready : result handshake; out_idx/out_max hold the vector's argmax
module argmax_stream
    import argmax_stream_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned K      = 4,
    parameter int unsigned I      = 4,
    parameter int unsigned P      = 1,
    parameter bit          SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P*K-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [I-1:0] out_idx,
    output logic [K-1:0] out_max
);

    localparam int unsigned Beats = N / P;
    localparam int unsigned CntW  = clog2_min1(Beats);
    localparam int unsigned LaneW = clog2_min1(P);
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);
    localparam bit SingleBeat = (Beats == 1);

    if (N % P != 0) begin : gen_chk_np
        $error("argmax_stream: N must be a multiple of P");
    end
    if (I < $clog2(N)) begin : gen_chk_i
        $error("argmax_stream: I too narrow for N");
    end

    function automatic logic gt(input logic [K-1:0] a, input logic [K-1:0] b);
        if (SIGNED) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic [K-1:0]    run_max_q, run_max_d;
    logic [I-1:0]    run_idx_q, run_idx_d;

    logic [K-1:0]     beat_max;
    logic [LaneW-1:0] beat_lane;
    logic [I-1:0]     cand_idx;
    logic             in_hs;
    state_e           first_state;
    logic [CntW-1:0]  first_cnt;

    argmax_tree #(
        .P      (P),
        .K      (K),
        .SIGNED (SIGNED)
    ) u_tree (
        .data_i (in_data),
        .max_o  (beat_max),
        .lane_o (beat_lane)
    );

    // beat_cnt_q is zero whenever a new vector can start, so the first beat indexes from 0.
    assign cand_idx    = I'(32'(beat_cnt_q) * P + 32'(beat_lane));
    assign in_ready    = (state_q != StDone) | out_ready;
    assign in_hs       = in_valid & in_ready;
    assign first_state = SingleBeat ? StDone : StAcc;
    assign first_cnt   = SingleBeat ? '0 : CntW'(1);

    assign out_valid = (state_q == StDone);
    assign out_idx   = run_idx_q;
    assign out_max   = run_max_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        run_max_d  = run_max_q;
        run_idx_d  = run_idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_hs) begin
                    run_max_d  = beat_max;
                    run_idx_d  = cand_idx;
                    beat_cnt_d = first_cnt;
                    state_d    = first_state;
                end
            end
            StAcc: begin
                if (in_hs) begin
                    if (gt(beat_max, run_max_q)) begin
                        run_max_d = beat_max;
                        run_idx_d = cand_idx;
                    end
                    if (beat_cnt_q == LastBeat) begin
                        beat_cnt_d = '0;
                        state_d    = StDone;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                // in_hs here implies out_ready: the result leaves as the next vector starts.
                if (in_hs) begin
                    run_max_d  = beat_max;
                    run_idx_d  = cand_idx;
                    beat_cnt_d = first_cnt;
                    state_d    = first_state;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            run_max_q  <= '0;
            run_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            run_max_q  <= run_max_d;
            run_idx_q  <= run_idx_d;
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: four instances (P=8 unsigned, P=8 signed, P=1, P=4), each with
// a driver, a whole-vector argmax model and a per-cycle compare process.
module tb_argmax_stream;

    logic clk;
    int   errors = 0;
    int   checks = 0;
    bit   done [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int cfg, input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0d expected %0d", cfg, name, got, exp);
        end
    endtask

    function automatic int sval(input logic [3:0] x, input bit s);
        return s ? {{28{x[3]}}, x} : {28'b0, x};
    endfunction

    // Reference: scan all 8 elements, first occurrence of the largest value wins.
    function automatic int model_idx(input logic [31:0] v, input bit s);
        int best = 0;
        for (int e = 1; e < 8; e++) begin
            if (sval(v[e*4 +: 4], s) > sval(v[best*4 +: 4], s)) best = e;
        end
        return best;
    endfunction

    function automatic int model_max(input logic [31:0] v, input bit s);
        int b = model_idx(v, s);
        return int'(v[b*4 +: 4]);
    endfunction

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        for (int e = 0; e < 8; e++) begin
            v[e*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(13, 15));
        end
        return v;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int unsigned P     = (g < 2) ? 8 : ((g == 2) ? 1 : 4);
        localparam bit          S     = (g == 1);
        localparam int unsigned PKW   = P * 4;
        localparam int unsigned BEATS = 8 / P;
        localparam int unsigned RST_BEATS = (BEATS > 1) ? (BEATS * 5) / 8 : 1;
        localparam logic [31:0] VEC1  = 32'h12e9f3d3;
        localparam int          EXP1_IDX = S ? 0 : 3;
        localparam int          EXP1_MAX = S ? 3 : 15;
        localparam logic [31:0] VEC2  = 32'h4716a529;
        localparam int          EXP2_IDX = S ? 6 : 3;
        localparam int          EXP2_MAX = S ? 7 : 10;

        logic           rst;
        logic           in_valid;
        logic           in_ready;
        logic [PKW-1:0] in_data;
        logic           out_valid;
        logic           out_ready;
        logic [3:0]     out_idx;
        logic [3:0]     out_max;
        bit             rmode;

        argmax_stream #(
            .N      (8),
            .K      (4),
            .I      (4),
            .P      (P),
            .SIGNED (S)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_idx   (out_idx),
            .out_max   (out_max)
        );

        // Compare process: rebuilds vectors from accepted beats, expects each result the
        // cycle after its last beat and holds it until consumed.
        int          exp_idx_q [$];
        int          exp_max_q [$];
        logic [31:0] acc_vec;
        int          nb = 0;
        bit          rst_seen = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                exp_idx_q.delete();
                exp_max_q.delete();
                nb       = 0;
                rst_seen = 1'b1;
            end else begin
                if (rst_seen) begin
                    check(g, "reset_out_valid", out_valid, 0);
                    check(g, "reset_out_idx", out_idx, 0);
                    check(g, "reset_out_max", out_max, 0);
                    check(g, "reset_in_ready", in_ready, 1);
                    rst_seen = 1'b0;
                end else begin
                    check(g, "out_valid", out_valid, exp_idx_q.size() != 0);
                    if (exp_idx_q.size() != 0) begin
                        check(g, "out_idx", out_idx, exp_idx_q[0]);
                        check(g, "out_max", out_max, exp_max_q[0]);
                    end
                    check(g, "in_ready", in_ready, (exp_idx_q.size() == 0) || out_ready);
                end
                if (out_valid && out_ready && exp_idx_q.size() != 0) begin
                    void'(exp_idx_q.pop_front());
                    void'(exp_max_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    acc_vec[nb*PKW +: PKW] = in_data;
                    nb++;
                    if (nb == BEATS) begin
                        exp_idx_q.push_back(model_idx(acc_vec, S));
                        exp_max_q.push_back(model_max(acc_vec, S));
                        nb = 0;
                    end
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
            if (rmode) out_ready = ($urandom_range(0, 3) != 0);
        endtask

        task automatic send_beat(input logic [PKW-1:0] d, output int waits);
            waits    = 0;
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            while (!in_ready && waits < 100) begin
                tick();
                @(negedge clk);
                waits++;
            end
            check(g, "beat_accepted", in_ready, 1);
            tick();
            in_valid = 1'b0;
            in_data  = PKW'($urandom);
        endtask

        task automatic send_vec(input logic [31:0] v, input int gapmode, output int waits);
            int w;
            waits = 0;
            for (int b = 0; b < BEATS; b++) begin
                send_beat(v[b*PKW +: PKW], w);
                waits += w;
                if (gapmode == 1) tick();
                else if (gapmode == 2) repeat ($urandom_range(0, 2)) tick();
            end
        endtask

        task automatic wait_valid();
            int w = 0;
            @(negedge clk);
            while (!out_valid && w < 50) begin
                tick();
                @(negedge clk);
                w++;
            end
            check(g, "result_arrives", out_valid, 1);
        endtask

        task automatic consume();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        endtask

        initial begin
            logic [31:0] v;
            int          w;
            int          tot;
            rst       = 1'b1;
            in_valid  = 1'b0;
            in_data   = '0;
            out_ready = 1'b0;
            rmode     = 1'b0;
            repeat (3) tick();
            rst = 1'b0;
            tick();

            // Directed vector with a one-cycle gap after every beat.
            v = VEC1;
            send_vec(v, 1, w);
            wait_valid();
            check(g, "vec1_idx", out_idx, EXP1_IDX);
            check(g, "vec1_max", out_max, EXP1_MAX);

            // Hold the result with the next vector's first beat already offered.
            v        = VEC2;
            in_valid = 1'b1;
            in_data  = v[PKW-1:0];
            for (int i = 0; i < 5; i++) begin
                tick();
                @(negedge clk);
                check(g, "hold_in_ready", in_ready, 0);
                check(g, "hold_out_valid", out_valid, 1);
                check(g, "hold_out_idx", out_idx, EXP1_IDX);
                check(g, "hold_out_max", out_max, EXP1_MAX);
            end
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            check(g, "restart_accept", in_ready, 1);
            tick();
            out_ready = 1'b0;
            in_valid  = 1'b0;
            for (int b = 1; b < BEATS; b++) begin
                send_beat(v[b*PKW +: PKW], w);
            end
            wait_valid();
            check(g, "vec2_idx", out_idx, EXP2_IDX);
            check(g, "vec2_max", out_max, EXP2_MAX);
            consume();

            // Reset part-way through a vector (or while a single-beat result is held).
            v = VEC1;
            for (int b = 0; b < RST_BEATS; b++) begin
                send_beat(v[b*PKW +: PKW], w);
            end
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            @(negedge clk);
            check(g, "post_rst_valid", out_valid, 0);
            check(g, "post_rst_ready", in_ready, 1);
            tick();
            v = 32'h07000000;
            send_vec(v, 0, w);
            wait_valid();
            check(g, "vec3_idx", out_idx, 6);
            check(g, "vec3_max", out_max, 7);
            consume();

            // Sustained throughput: no stall with out_ready high and beats back to back.
            out_ready = 1'b1;
            tot       = 0;
            for (int n = 0; n < 4; n++) begin
                send_vec(rand_vec(), 0, w);
                tot += w;
            end
            check(g, "throughput_stalls", tot, 0);

            // Random traffic on both handshakes.
            rmode = 1'b1;
            for (int n = 0; n < 40; n++) begin
                send_vec(rand_vec(), 2, w);
            end
            rmode     = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 30 && exp_idx_q.size() != 0; i++) tick();
            check(g, "drained", exp_idx_q.size(), 0);
            done[g] = 1'b1;
        end
    end

    initial begin
        int t = 0;
        // Pin the reference model to hand-worked answers.
        check(-1, "model_u_idx", model_idx(32'h12e9f3d3, 1'b0), 3);
        check(-1, "model_u_max", model_max(32'h12e9f3d3, 1'b0), 15);
        check(-1, "model_s_idx", model_idx(32'h12e9f3d3, 1'b1), 0);
        check(-1, "model_s_max", model_max(32'h12e9f3d3, 1'b1), 3);
        check(-1, "model_tie_idx", model_idx(32'hf2e9f3d3, 1'b0), 3);
        check(-1, "model_one_idx", model_idx(32'h07000000, 1'b0), 6);
        while (!(done[0] && done[1] && done[2] && done[3]) && t < 50000) begin
            @(posedge clk);
            t++;
        end
        check(-1, "all_configs_done", done[0] && done[1] && done[2] && done[3], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Streaming, parametrised argmax for the BNN classifier output stage. Accepts a score vector of N elements, P elements per beat, over a valid/ready handshake. Tracks the running maximum and its index across beats and emits one (index, max) result per vector on an output valid/ready handshake. It supersedes the purely combinational argmax when N·K is too wide for one cycle or scores arrive serially from the popcount layer.

## Interface
- N, 8: elements per vector; must be a multiple of P.
- K, 4: bits per score.
- I, 4: index width; I ≥ clog2(N).
- P, 1: elements per input beat (lanes); 1 ≤ P ≤ N.
- SIGNED, 0: 0 = scores unsigned, 1 = two's complement.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  P*K  lane j at bits [j*K +: K]; lane 0 is the lowest element index in the beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_idx  out  I  index of maximum, 0..N-1.
- out_max  out  K  maximum score.

## Operation
- Element order: beat b, lane j carries element b·P + j. With P = N, element e sits at in_data[e*K +: K] (LSB-first).
- Compare rule: strict greater-than, signed or unsigned per SIGNED. Ties keep the lowest index, both within a beat and across beats.
- Per beat, a P-lane reduction yields (beat_max, lane) under the same tie rule. Candidate index = beat_cnt·P + lane, width I.
- FSM states:
  - IDLE: no partial vector. A handshake (in_valid & in_ready) loads run_max and run_idx directly from the beat result, with no compare. Next state is ACC, or DONE if N/P = 1.
  - ACC: each handshake replaces run_max and run_idx only if beat_max > run_max, then increments beat_cnt. The handshake on beat N/P−1 moves to DONE.
  - DONE: out_valid = 1, and out_idx/out_max hold the run registers, stable until out_ready. On out_valid & out_ready: with no simultaneous input handshake, go to IDLE; with a simultaneous input handshake, that beat starts the next vector, loads as in IDLE, and the next state is ACC (or DONE if N/P = 1).
- in_ready = (state != DONE) | out_ready. Beats are never dropped or duplicated.
- in_data is ignored when in_valid = 0. In-flight data is not affected by a change of in_data while in_ready = 0.

## Timing
- Reset values: state IDLE, beat_cnt 0, out_valid 0, out_idx 0, out_max 0, in_ready 1 in the cycle after reset.
- Reset asserted mid-vector or in DONE discards the partial vector or result. No output handshake occurs.
- Latency: out_valid rises the cycle after the final beat's handshake.
- Throughput: one vector per N/P cycles sustained, with out_ready held high and in_valid continuous. There are no bubbles.
- Comparison plus index formation is single-cycle combinational from in_data to the run registers. No output is combinationally dependent on in_data. in_ready depends combinationally on out_ready only.

## Structure
- The shared package holds the FSM state enum (IDLE, ACC, DONE) and a clog2-based localparam helper for beat_cnt width = max(1, clog2(N/P)).
- Sub-module argmax_tree (parameters P, K, SIGNED) is a combinational P-lane reduction that outputs the max and the lane index (width max(1, clog2(P))), lowest-lane-wins on ties. It is reusable as the combinational argmax generalisation.
- The top holds the FSM, beat counter, run registers, and handshake logic.
- Elaboration checks: N % P == 0, and I ≥ clog2(N).

## Test plan
- N=8, K=4, P=8, SIGNED=0, in_data=32'h12e9f3d3 (elements 3,d,3,f,9,e,2,1) → out_idx=3, out_max=4'hf one cycle after the handshake.
- Same vector, SIGNED=1 (3,−3,3,−1,−7,−2,2,1) → out_idx=0, out_max=4'h3. Tests the tie between index 0 and index 2.
- P=1, 8 consecutive beats of the same vector with in_valid throttled 50% → out_idx=3, out_max=f. out_valid appears exactly once, one cycle after beat 7.
- P=4, beats 16'hf3d3 then 16'hf2e9 (max f in both beats) → out_idx=3: the earlier beat wins the cross-beat tie.
- Back-pressure: out_ready=0 for 5 cycles in DONE → in_ready=0 and the outputs are stable. When out_ready rises with in_valid high, the next vector's first beat is accepted in the same cycle, and the second result is correct.
- rst asserted after 5 of 8 beats (P=1) → out_valid stays 0. A following full vector 8 × {4'h0 except element 6 = 4'h7} yields out_idx=6, out_max=7.
